// File: rtl/codec_filter_sequencer.sv
// Frame sequencer between the audio codec and one shared filter engine:
// codec read -> filter left -> filter right -> codec write, with a bypass mode and filter timeouts.
module codec_filter_sequencer #(
  parameter int WIDTH   = 24,
  parameter int TIMEOUT = 64,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             read_ready,
  input  logic [WIDTH-1:0] readdata_left,
  input  logic [WIDTH-1:0] readdata_right,
  input  logic             write_ready,
  output logic             read,
  output logic             write,
  output logic [WIDTH-1:0] writedata_left,
  output logic [WIDTH-1:0] writedata_right,
  output logic             flt_start,
  output logic             flt_chan,
  output logic [WIDTH-1:0] flt_in,
  input  logic             flt_done,
  input  logic [WIDTH-1:0] flt_out,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
);

  // state  | meaning
  // IDLE   | waiting for a codec sample pair
  // ACK    | read ack to codec, choose filter or bypass
  // FILT_L | filter request for left channel
  // WAIT_L | waiting for left result or timeout
  // FILT_R | filter request for right channel
  // WAIT_R | waiting for right result or timeout
  // WRITE  | result pair presented, waiting for write_ready
  typedef enum logic [2:0] {
    IDLE, ACK, FILT_L, WAIT_L, FILT_R, WAIT_R, WRITE
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           state;
  logic             mode;
  logic [WIDTH-1:0] smp_l;
  logic [WIDTH-1:0] smp_r;
  logic [WIDTH-1:0] res_l;
  logic [TW-1:0]    timer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      mode            <= 1'b0;
      smp_l           <= '0;
      smp_r           <= '0;
      res_l           <= '0;
      timer           <= '0;
      read            <= 1'b0;
      write           <= 1'b0;
      writedata_left  <= '0;
      writedata_right <= '0;
      flt_start       <= 1'b0;
      flt_chan        <= 1'b0;
      flt_in          <= '0;
      busy            <= 1'b0;
      err_cnt         <= '0;
    end else begin
      read      <= 1'b0;
      write     <= 1'b0;
      flt_start <= 1'b0;
      case (state)
        IDLE: begin
          if (read_ready) begin
            smp_l <= readdata_left;
            smp_r <= readdata_right;
            mode  <= enable;
            read  <= 1'b1;
            busy  <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          if (mode) begin
            flt_start <= 1'b1;
            flt_chan  <= 1'b0;
            flt_in    <= smp_l;
            state     <= FILT_L;
          end else begin
            writedata_left  <= smp_l;
            writedata_right <= smp_r;
            state           <= WRITE;
          end
        end
        FILT_L: begin
          // timer holds the 1-based index of the current wait cycle
          timer <= TW'(1);
          state <= WAIT_L;
        end
        WAIT_L: begin
          if (flt_done || timer == TMAX) begin
            if (flt_done) begin
              res_l <= flt_out;
            end else begin
              res_l <= smp_l;
              if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
            end
            flt_start <= 1'b1;
            flt_chan  <= 1'b1;
            flt_in    <= smp_r;
            state     <= FILT_R;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        FILT_R: begin
          timer <= TW'(1);
          state <= WAIT_R;
        end
        WAIT_R: begin
          if (flt_done || timer == TMAX) begin
            writedata_left <= res_l;
            if (flt_done) begin
              writedata_right <= flt_out;
            end else begin
              writedata_right <= smp_r;
              if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
            end
            state <= WRITE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WRITE: begin
          if (write_ready) begin
            write <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_codec_filter_sequencer.sv
// Scoreboard bench for codec_filter_sequencer: expected write pairs are queued when a frame
// is offered and checked when the sequencer strobes write.
module tb_codec_filter_sequencer;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        read_ready = 1'b0;
  logic [23:0] readdata_left = '0;
  logic [23:0] readdata_right = '0;
  logic        write_ready = 1'b0;
  logic        flt_done = 1'b0;
  logic [23:0] flt_out = '0;
  logic        read, write, flt_start, flt_chan, busy;
  logic [23:0] writedata_left, writedata_right, flt_in;
  logic [7:0]  err_cnt;

  frame_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int fs_cnt = 0;

  codec_filter_sequencer #(.WIDTH(24), .TIMEOUT(64), .ERR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .read_ready(read_ready),
    .readdata_left(readdata_left), .readdata_right(readdata_right),
    .write_ready(write_ready), .read(read), .write(write),
    .writedata_left(writedata_left), .writedata_right(writedata_right),
    .flt_start(flt_start), .flt_chan(flt_chan), .flt_in(flt_in),
    .flt_done(flt_done), .flt_out(flt_out), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (read) rd_cnt <= rd_cnt + 1;
    if (write) wr_cnt <= wr_cnt + 1;
    if (flt_start) fs_cnt <= fs_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one frame and queue its expected write pair; returns the cycle it was offered.
  task automatic start_frame(input logic en, input logic [23:0] l, input logic [23:0] r,
                             input logic [23:0] el, input logic [23:0] er, output int t0);
    frame_t f;
    bit got;
    @(posedge clk); #1;
    t0 = cyc;
    enable = en; readdata_left = l; readdata_right = r; read_ready = 1'b1;
    f.l = el; f.r = er;
    sb.push_back(f);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (read) begin got = 1; break; end
    end
    read_ready = 1'b0;
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL read_ack: got no read, expected read within 10 cycles");
    end
  endtask

  // Wait for a filter request, check it, and optionally answer d cycles into the wait state.
  task automatic serve(input logic exp_chan, input logic [23:0] exp_in, input int d,
                       input logic [23:0] val, input bit respond, output int t);
    bit got;
    got = 0;
    t = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (flt_start) begin got = 1; break; end
    end
    t = cyc;
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL flt_start: got none, expected request on chan %0d", exp_chan);
      return;
    end
    n_cmp++;
    if (flt_chan !== exp_chan || flt_in !== exp_in) begin
      n_err++;
      $display("FAIL flt_req: got chan %0d in %h, expected chan %0d in %h",
               flt_chan, flt_in, exp_chan, exp_in);
    end
    if (respond) begin
      repeat (d) @(posedge clk);
      #1; flt_out = val; flt_done = 1'b1;
      @(posedge clk); #1; flt_done = 1'b0;
    end
  endtask

  // Wait for a write strobe and compare it against the oldest queued frame.
  task automatic wait_write(input string name, output int t);
    frame_t f;
    bit got;
    got = 0;
    t = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (write) begin got = 1; break; end
    end
    t = cyc;
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s write: got no write strobe, expected one within 400 cycles", name);
    end else if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s write: got write %h/%h, expected no write", name,
               writedata_left, writedata_right);
    end else begin
      f = sb.pop_front();
      if (writedata_left !== f.l || writedata_right !== f.r) begin
        n_err++;
        $display("FAIL %s data: got %h/%h, expected %h/%h", name,
                 writedata_left, writedata_right, f.l, f.r);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({read, write, flt_start, flt_chan, busy} !== 5'b0 || writedata_left !== 24'h0 ||
        writedata_right !== 24'h0 || flt_in !== 24'h0 || err_cnt !== 8'h0) begin
      n_err++;
      $display("FAIL reset: got ctl %b wd %h/%h fin %h err %0d, expected all zero",
               {read, write, flt_start, flt_chan, busy}, writedata_left, writedata_right,
               flt_in, err_cnt);
    end
    @(posedge clk); #1; reset_n = 1'b1;
  endtask

  task automatic test_bypass();
    int rd0, wr0, fs0, t0, t1;
    rd0 = rd_cnt; wr0 = wr_cnt; fs0 = fs_cnt;
    write_ready = 1'b1;
    start_frame(1'b0, 24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA, t0);
    wait_write("bypass", t1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rd_cnt - rd0 != 1 || wr_cnt - wr0 != 1 || fs_cnt - fs0 != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bypass pulses: got read %0d write %0d flt_start %0d busy %b, expected 1 1 0 0",
               rd_cnt - rd0, wr_cnt - wr0, fs_cnt - fs0, busy);
    end
  endtask

  task automatic test_filter();
    int t0, t1, tl, tr;
    write_ready = 1'b1;
    start_frame(1'b1, 24'h0A0B0C, 24'h0D0E0F, 24'h000100, 24'hFFFF00, t0);
    serve(1'b0, 24'h0A0B0C, 3, 24'h000100, 1'b1, tl);
    serve(1'b1, 24'h0D0E0F, 3, 24'hFFFF00, 1'b1, tr);
    wait_write("filter", t1);
    n_cmp++;
    if (err_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL filter err_cnt: got %0d, expected 0", err_cnt);
    end
  endtask

  task automatic test_latency();
    int t0, t1, tl, tr;
    start_frame(1'b1, 24'h314159, 24'h271828, 24'hA00001, 24'hB00002, t0);
    serve(1'b0, 24'h314159, 1, 24'hA00001, 1'b1, tl);
    serve(1'b1, 24'h271828, 1, 24'hB00002, 1'b1, tr);
    wait_write("latency", t1);
    n_cmp++;
    if (t1 - t0 != 7) begin
      n_err++;
      $display("FAIL latency: got %0d cycles, expected 7", t1 - t0);
    end
  endtask

  task automatic test_collision();
    int t0, t1, tl, tr;
    logic [7:0] e0;
    e0 = err_cnt;
    start_frame(1'b1, 24'h0F0F0F, 24'hF0F0F0, 24'h111111, 24'h222222, t0);
    serve(1'b0, 24'h0F0F0F, 64, 24'h111111, 1'b1, tl);
    serve(1'b1, 24'hF0F0F0, 64, 24'h222222, 1'b1, tr);
    wait_write("collision", t1);
    n_cmp++;
    if (err_cnt !== e0) begin
      n_err++;
      $display("FAIL collision err_cnt: got %0d, expected %0d", err_cnt, e0);
    end
  endtask

  task automatic test_timeout();
    int t0, t1, tl, tr;
    start_frame(1'b1, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, t0);
    serve(1'b0, 24'h7FFFFF, 0, 24'h0, 1'b0, tl);
    serve(1'b1, 24'h800000, 0, 24'h0, 1'b0, tr);
    wait_write("timeout", t1);
    n_cmp++;
    if (tr - tl != 65) begin
      n_err++;
      $display("FAIL timeout wait length: got %0d cycles between requests, expected 65", tr - tl);
    end
    n_cmp++;
    if (err_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL timeout err_cnt: got %0d, expected 2", err_cnt);
    end
  endtask

  task automatic test_backpressure();
    frame_t f;
    int rd0, wr0, t1, unstable;
    write_ready = 1'b0;
    @(posedge clk); #1;
    enable = 1'b0; readdata_left = 24'h0055AA; readdata_right = 24'hAA5500; read_ready = 1'b1;
    f.l = 24'h0055AA; f.r = 24'hAA5500;
    sb.push_back(f);
    sb.push_back(f);
    rd0 = rd_cnt; wr0 = wr_cnt; unstable = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i >= 5 && (writedata_left !== 24'h0055AA || writedata_right !== 24'hAA5500))
        unstable++;
    end
    n_cmp++;
    if (rd_cnt - rd0 != 1 || wr_cnt - wr0 != 0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure hold: got reads %0d writes %0d busy %b, expected 1 0 1",
               rd_cnt - rd0, wr_cnt - wr0, busy);
    end
    n_cmp++;
    if (unstable != 0) begin
      n_err++;
      $display("FAIL backpressure stable: got %0d unstable cycles, expected 0", unstable);
    end
    @(posedge clk); #1; write_ready = 1'b1;
    wait_write("backpressure first", t1);
    repeat (2) @(negedge clk);
    read_ready = 1'b0;
    n_cmp++;
    if (rd_cnt - rd0 != 2) begin
      n_err++;
      $display("FAIL backpressure next frame: got %0d reads, expected 2", rd_cnt - rd0);
    end
    wait_write("backpressure second", t1);
  endtask

  task automatic test_saturation();
    int t0, t1, tl, tr;
    logic [23:0] l, r;
    write_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      l = 24'(k * 7 + 1);
      r = 24'(k * 13 + 5);
      start_frame(1'b1, l, r, l, r, t0);
      serve(1'b0, l, 0, 24'h0, 1'b0, tl);
      serve(1'b1, r, 0, 24'h0, 1'b0, tr);
      wait_write("saturation", t1);
    end
    n_cmp++;
    if (err_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL saturation err_cnt: got %0d, expected 255", err_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int t0, t1, tl, tr, fs0;
    start_frame(1'b1, 24'h111000, 24'h222000, 24'h0, 24'h0, t0);
    serve(1'b0, 24'h111000, 1, 24'h333000, 1'b1, tl);
    serve(1'b1, 24'h222000, 0, 24'h0, 1'b0, tr);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({read, write, flt_start, flt_chan, busy} !== 5'b0 || writedata_left !== 24'h0 ||
        writedata_right !== 24'h0 || flt_in !== 24'h0 || err_cnt !== 8'h0) begin
      n_err++;
      $display("FAIL midframe reset: got ctl %b wd %h/%h fin %h err %0d, expected all zero",
               {read, write, flt_start, flt_chan, busy}, writedata_left, writedata_right,
               flt_in, err_cnt);
    end
    sb.delete();
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1;
    fs0 = fs_cnt;
    @(posedge clk); #1; flt_out = 24'hDEAD00; flt_done = 1'b1;
    @(posedge clk); #1; flt_done = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || fs_cnt != fs0 || writedata_left !== 24'h0) begin
      n_err++;
      $display("FAIL stale flt_done: got busy %b requests %0d wdl %h, expected 0 0 000000",
               busy, fs_cnt - fs0, writedata_left);
    end
    start_frame(1'b1, 24'h444000, 24'h555000, 24'h666000, 24'h777000, t0);
    serve(1'b0, 24'h444000, 2, 24'h666000, 1'b1, tl);
    serve(1'b1, 24'h555000, 2, 24'h777000, 1'b1, tr);
    wait_write("post reset", t1);
    n_cmp++;
    if (err_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL post reset err_cnt: got %0d, expected 0", err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_filter();
    test_latency();
    test_collision();
    test_timeout();
    test_backpressure();
    test_saturation();
    test_reset_midframe();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending frames, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
